// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types for the load/store unit: FSM states, func3 codes
//               and the natural-alignment rule.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'd0,
        F3_LH  = 3'd1,
        F3_LW  = 3'd2,
        F3_LBU = 3'd4,
        F3_LHU = 3'd5
    } ld_func3_e;

    typedef enum logic [2:0] {
        F3_SB = 3'd0,
        F3_SH = 3'd1,
        F3_SW = 3'd2
    } st_func3_e;

    // Unlisted func3 codes (3/6/7) behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
        case (func3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return off[0];
            default:       return off != 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : Decoder-side operation and data-memory bus signals of the LSU.
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic          in_wen;
    logic [2:0]    in_func3;
    logic [7:0]    in_wmask;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_wstrb;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          done;
    logic [DW-1:0] rdata;
    logic          err;

    // master: the LSU itself; slave: decoder plus data memory around it
    modport master (
        input  in_valid, in_wen, in_func3, in_wmask, in_addr, in_wdata,
               req_ready, rsp_valid, rsp_rdata,
        output in_ready, req_valid, req_wen, req_addr, req_wstrb, req_wdata,
               done, rdata, err
    );

    modport slave (
        output in_valid, in_wen, in_func3, in_wmask, in_addr, in_wdata,
               req_ready, rsp_valid, rsp_rdata,
        input  in_ready, req_valid, req_wen, req_addr, req_wstrb, req_wdata,
               done, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational store data/strobe lane shifting and load data
//               extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    st_mask,
    input  logic [DW-1:0] st_data,
    input  logic [1:0]    st_off,
    output logic [3:0]    st_strb,
    output logic [DW-1:0] st_shifted,
    input  logic [DW-1:0] ld_word,
    input  logic [2:0]    ld_func3,
    input  logic [1:0]    ld_off,
    output logic [DW-1:0] ld_data
);

    logic [DW-1:0] w_ld_shifted;

    // Strobe bits pushed past lane 3 fall off: accesses never straddle a word.
    always_comb begin
        st_strb      = st_mask << st_off;
        st_shifted   = st_data << {st_off, 3'b000};
        w_ld_shifted = ld_word >> {ld_off, 3'b000};
        case (ld_func3)
            F3_LB:   ld_data = {{(DW-8){w_ld_shifted[7]}}, w_ld_shifted[7:0]};
            F3_LH:   ld_data = {{(DW-16){w_ld_shifted[15]}}, w_ld_shifted[15:0]};
            F3_LBU:  ld_data = {{(DW-8){1'b0}}, w_ld_shifted[7:0]};
            F3_LHU:  ld_data = {{(DW-16){1'b0}}, w_ld_shifted[15:0]};
            default: ld_data = w_ld_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Single-outstanding load/store unit. Define
//               LSU_MISALIGN_CHECK_EN to trap misaligned halfword/word ops.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    lsu_if.master  bus
);

    lsu_state_e    r_state;
    logic          r_in_ready;
    logic          r_req_valid;
    logic          r_req_wen;
    logic [AW-1:0] r_req_addr;
    logic [3:0]    r_req_wstrb;
    logic [DW-1:0] r_req_wdata;
    logic          r_done;
    logic [DW-1:0] r_rdata;
    logic [2:0]    r_func3;
    logic [1:0]    r_off;
`ifdef LSU_MISALIGN_CHECK_EN
    logic          r_err;
`endif

    logic [3:0]    w_st_strb;
    logic [DW-1:0] w_st_data;
    logic [DW-1:0] w_ld_data;
    logic          w_unused_wmask;

    assign w_unused_wmask = ^bus.in_wmask[7:4];

    // Store lanes come from the live inputs and are registered at accept;
    // load extraction works on the captured offset/func3.
    lsu_align #(.DW(DW)) u_align (
        .st_mask    (bus.in_wmask[3:0]),
        .st_data    (bus.in_wdata),
        .st_off     (bus.in_addr[1:0]),
        .st_strb    (w_st_strb),
        .st_shifted (w_st_data),
        .ld_word    (bus.rsp_rdata),
        .ld_func3   (r_func3),
        .ld_off     (r_off),
        .ld_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_req_valid <= 1'b0;
            r_req_wen   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wstrb <= '0;
            r_req_wdata <= '0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_func3     <= '0;
            r_off       <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_req_wen   <= bus.in_wen;
                        r_req_addr  <= {bus.in_addr[AW-1:2], 2'b00};
                        r_req_wstrb <= w_st_strb;
                        r_req_wdata <= w_st_data;
                        r_func3     <= bus.in_func3;
                        r_off       <= bus.in_addr[1:0];
                        r_in_ready  <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
                        if (is_misaligned(bus.in_func3, bus.in_addr[1:0])) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= ST_REQ;
                            r_req_valid <= 1'b1;
                        end
`else
                        r_state     <= ST_REQ;
                        r_req_valid <= 1'b1;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus.req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (bus.rsp_valid) begin
                        if (!r_req_wen) begin
                            r_rdata <= w_ld_data;
                        end
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_req_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.req_valid = r_req_valid;
    assign bus.req_wen   = r_req_wen;
    assign bus.req_addr  = r_req_addr;
    assign bus.req_wstrb = r_req_wstrb;
    assign bus.req_wdata = r_req_wdata;
    assign bus.done      = r_done;
    assign bus.rdata     = r_rdata;
`ifdef LSU_MISALIGN_CHECK_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Randomised scoreboard bench for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if #(.AW(AW), .DW(DW)) bus ();
    lsu #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] word;
        int          dreq;
        int          drsp;
    } plan_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] model_rdata = 32'h0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit misalign_model(input logic [2:0] f3, input int off);
        return (off % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [2:0] f3, input int off);
        longint v;
        longint lim;
        int     sz;
        sz = size_of(f3);
        v  = longint'(word);
        v  = v / (longint'(1) << (8 * off));
        if (sz < 4) begin
            lim = longint'(1) << (8 * sz);
            v   = v % lim;
            if (!f3[2] && v >= lim / 2) v = v - lim;
        end
        return v[31:0];
    endfunction

    function automatic logic [3:0] strobe_model(input logic [7:0] wm, input int off);
        logic [3:0] s;
        s = 4'h0;
        for (int i = 0; i < 4; i++) if (i >= off) s[i] = wm[i - off];
        return s;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] wd, input int off);
        logic [31:0] w;
        w = 32'h0;
        for (int i = 0; i < 4; i++) if (i >= off) w[8*i +: 8] = wd[8*(i - off) +: 8];
        return w;
    endfunction

    // ---------------- stimulus ----------------
    task automatic drive_noise();
        bus.in_valid = bus.in_ready ? 1'b0 : 1'($urandom_range(0, 1));
        bus.in_wen   = 1'($urandom_range(0, 1));
        bus.in_func3 = 3'($urandom_range(0, 7));
        bus.in_wmask = 8'($urandom_range(0, 255));
        bus.in_addr  = $urandom;
        bus.in_wdata = $urandom;
    endtask

    task automatic issue(input logic wen, input logic [2:0] f3, input logic [7:0] wm,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] word, input int dreq, input int drsp);
        int    t;
        int    off;
        bit    bad;
        plan_t p;
        exp_t  e;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            drive_noise();
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready still 0 after %0d cycles", t);
            return;
        end
        off = int'(addr[1:0]);
        bad = MIS_EN && misalign_model(f3, off);
        if (!bad && !wen) model_rdata = load_model(word, f3, off);
        e.rdata = model_rdata;
        e.err   = bad;
        e.cyc   = cyc + (bad ? 1 : 3 + dreq + drsp);
        exp_q.push_back(e);
        if (!bad) begin
            p.wen   = wen;
            p.addr  = addr & 32'hffff_fffc;
            p.wstrb = strobe_model(wm, off);
            p.wdata = wdata_model(wdata, off);
            p.word  = word;
            p.dreq  = dreq;
            p.drsp  = drsp;
            plan_q.push_back(p);
        end
        bus.in_valid = 1'b1;
        bus.in_wen   = wen;
        bus.in_func3 = f3;
        bus.in_wmask = wm;
        bus.in_addr  = addr;
        bus.in_wdata = wdata;
        @(negedge clk);
        drive_noise();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && t < 300) begin
            @(negedge clk);
            drive_noise();
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d operations never completed", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- memory responder ----------------
    task automatic check_req(input plan_t p);
        chk("req_valid", 32'(bus.req_valid), 32'h1);
        chk("req_addr", bus.req_addr, p.addr);
        chk("req_wen", 32'(bus.req_wen), 32'(p.wen));
        if (p.wen) begin
            chk("req_wstrb", 32'(bus.req_wstrb), 32'(p.wstrb));
            chk("req_wdata", bus.req_wdata, p.wdata);
        end
    endtask

    initial begin
        plan_t p;
        bit    ab;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = 32'h0;
        @(negedge clk);
        forever begin
            if (rst_n && bus.req_valid) begin
                bus.rsp_valid = 1'b0;
                ab = 1'b0;
                if (plan_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: request at %h with none pending", bus.req_addr);
                    bus.req_ready = 1'b1;
                    @(negedge clk);
                    bus.req_ready = 1'b0;
                end else begin
                    p = plan_q.pop_front();
                    for (int i = 0; i < p.dreq && !ab; i++) begin
                        bus.req_ready = 1'b0;
                        check_req(p);
                        @(negedge clk);
                        if (!rst_n) ab = 1'b1;
                    end
                    if (!ab) begin
                        check_req(p);
                        bus.req_ready = 1'b1;
                        @(negedge clk);
                        bus.req_ready = 1'b0;
                        for (int i = 0; i < p.drsp; i++) begin
                            bus.rsp_valid = 1'b0;
                            bus.rsp_rdata = $urandom;
                            @(negedge clk);
                        end
                        bus.rsp_valid = 1'b1;
                        bus.rsp_rdata = p.word;
                        @(negedge clk);
                        bus.rsp_valid = 1'b0;
                    end
                end
            end else begin
                // stray handshakes outside REQ/RSP must be ignored
                bus.req_ready = 1'($urandom_range(0, 1));
                bus.rsp_valid = 1'($urandom_range(0, 1));
                bus.rsp_rdata = $urandom;
                @(negedge clk);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() == 0));
            if (bus.done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done with nothing outstanding, rdata %h", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", bus.rdata, e.rdata);
                    chk("err", 32'(bus.err), 32'(e.err));
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (bus.err) begin
                checks++;
                errors++;
                $display("FAIL err_without_done: err=1 done=0");
            end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL done_late: no done by cycle %0d", exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] wm;
        int         gap;
        int         dc;
        bus.in_valid = 1'b0;
        bus.in_wen   = 1'b0;
        bus.in_func3 = 3'd0;
        bus.in_wmask = 8'h0;
        bus.in_addr  = 32'h0;
        bus.in_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_req_valid", 32'(bus.req_valid), 32'h0);
        chk("rst_req_wen", 32'(bus.req_wen), 32'h0);
        chk("rst_req_addr", bus.req_addr, 32'h0);
        chk("rst_req_wstrb", 32'(bus.req_wstrb), 32'h0);
        chk("rst_req_wdata", bus.req_wdata, 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;

        issue(1'b1, 3'd2, 8'h0f, 32'h8000_0004, 32'hdead_beef, 32'h0, 0, 0);
        issue(1'b1, 3'd0, 8'h01, 32'h8000_0003, 32'h0000_00a5, 32'h0, 0, 0);
        issue(1'b0, 3'd1, 8'h03, 32'h8000_0002, 32'h0, 32'h80f0_7f00, 0, 0);
        issue(1'b0, 3'd5, 8'h03, 32'h8000_1002, 32'h0, 32'h80f0_7f00, 0, 0);
        issue(1'b0, 3'd0, 8'h01, 32'h8000_2001, 32'h0, 32'h80f0_7f00, 0, 0);
        issue(1'b1, 3'd1, 8'h03, 32'h8000_0010, 32'h1234_5678, 32'h0, 3, 2);
        issue(1'b0, 3'd2, 8'h0f, 32'h8000_0002, 32'h0, 32'hcafe_f00d, 0, 0);
        issue(1'b1, 3'd1, 8'h03, 32'h8000_0003, 32'habcd_1234, 32'h0, 1, 0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0:       wm = {4'($urandom_range(0, 15)), 4'h1};
                1:       wm = {4'($urandom_range(0, 15)), 4'h3};
                default: wm = {4'($urandom_range(0, 15)), 4'hf};
            endcase
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(negedge clk);
                drive_noise();
            end
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), wm, $urandom, $urandom,
                  $urandom, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        drain();

        // reset while waiting for the response: late rsp_valid must not complete
        issue(1'b0, 3'd2, 8'h0f, 32'h8000_0100, 32'h0, 32'h1111_2222, 0, 6);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        plan_q.delete();
        model_rdata = 32'h0;
        #1;
        chk("rstrsp_req_valid", 32'(bus.req_valid), 32'h0);
        chk("rstrsp_in_ready", 32'(bus.in_ready), 32'h1);
        chk("rstrsp_rdata", bus.rdata, 32'h0);
        dc = done_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            drive_noise();
        end
        chk("rstrsp_no_done", done_count, dc);

        // reset while the request is stalled
        issue(1'b1, 3'd2, 8'h0f, 32'h8000_0200, 32'h5555_aaaa, 32'h0, 8, 0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        plan_q.delete();
        model_rdata = 32'h0;
        #1;
        chk("rstreq_req_valid", 32'(bus.req_valid), 32'h0);
        chk("rstreq_in_ready", 32'(bus.in_ready), 32'h1);
        dc = done_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            drive_noise();
        end
        chk("rstreq_no_done", done_count, dc);

        issue(1'b0, 3'd4, 8'h01, 32'h8000_0303, 32'h0, 32'h9a00_0000, 0, 0);
        issue(1'b1, 3'd2, 8'h0f, 32'h8000_0004, 32'hdead_beef, 32'h0, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
